imm_gen_pipe: RTL and testbench
===============================

Name: imm_gen_pipe

Overview:
Parametrised, pipelined immediate generator covering every RV64I/RV32I immediate format: I, S, B, U and J. It decodes the opcode and produces the sign-extended XLEN-bit immediate, a format code and a recognised flag, with a one-cycle registered latency. Input and output use valid/ready handshakes, backed by a 2-entry buffer (output register plus skid register). It sits between the fetch/instruction register and the decode/ALU-operand stage. A sideband tag (e.g. PC low bits) passes through aligned with each instruction.

Parameters:
XLEN, 64, immediate width; legal values 32 or 64.
TAG_W, 8, width of the pass-through tag; minimum 1.
CNT_W, 8, width of the saturating unrecognised-opcode counter.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  synchronous, active-low reset.
in_valid  in  1  instr/in_tag valid.
in_ready  out  1  block can accept; 0 while rst_n=0.
instr  in  32  instruction word.
in_tag  in  TAG_W  sideband tag.
out_valid  out  1  output entry valid.
out_ready  in  1  consumer accepts.
imm_out  out  XLEN  sign-extended immediate.
imm_fmt  out  3  0=NONE, 1=I, 2=S, 3=B, 4=U, 5=J.
imm_known  out  1  opcode recognised.
out_tag  out  TAG_W  tag aligned with imm_out.
err_cnt  out  CNT_W  count of accepted unrecognised opcodes.

Behaviour:
- Opcode map, from instr[6:0]:
  - 0000011, 0010011, 0011011, 1100111 -> I: sext(instr[31:20]).
  - 0100011 -> S: sext({instr[31:25], instr[11:7]}).
  - 1100011 -> B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
  - 0110111, 0010111 -> U: sext({instr[31:12], 12'b0}).
  - 1101111 -> J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
  - Any other opcode -> imm 0, fmt NONE, known 0.
- sext always replicates instr[31] up to XLEN. Shift-immediate funct bits are not stripped; downstream decode handles them.
- Accept and transfer rules:
  - An input is accepted when in_valid && in_ready.
  - An output is transferred when out_valid && out_ready.
- Latency and throughput: an accepted word appears on the outputs the next cycle. Throughput is one word per cycle while out_ready=1.
- Buffer state: EMPTY, ONE (output register full), TWO (output and skid both full). in_ready = rst_n && !skid_full, driven from a register with no combinational path from out_ready.
- EMPTY:
  - Accept -> ONE.
- ONE:
  - Transfer with accept -> stays ONE; new word loads the output register.
  - Transfer only -> EMPTY.
  - Accept without transfer -> TWO; new word goes to the skid register.
- TWO (in_ready=0, so no accept):
  - Transfer -> skid moves to the output register; next state ONE.
- Ordering and stability:
  - FIFO order is always preserved.
  - Outputs are held stable while out_valid && !out_ready.
  - Inputs are ignored when in_ready=0.
- err_cnt increments by 1 per accepted word with known=0 and saturates at 2^CNT_W-1. It never wraps.
- Reset (rst_n=0 at a clock edge), including mid-operation:
  - Both entries are discarded.
  - out_valid=0, imm_out=0, imm_fmt=0, imm_known=0, out_tag=0, err_cnt=0.
  - in_ready=0 during reset and 1 in the first cycle after release.
- Simultaneous reset and handshake: reset wins; nothing is accepted or counted.

Test Plan:
1. XLEN=64, out_ready=1; accept instr=0xFF813083 (ld x1,-8(x2)) tag 0x11 -> next cycle out_valid=1, imm_out=0xFFFFFFFFFFFFFFF8, fmt=1, known=1, out_tag=0x11.
2. Back-to-back, one word per cycle:
   - 0x00513823 -> imm 0x10, fmt 2.
   - 0xFE000EE3 -> imm 0xFFFFFFFFFFFFFFFC, fmt 3.
   - 0x800000B7 -> imm 0xFFFFFFFF80000000, fmt 4.
   - 0x001000EF -> imm 0x800, fmt 5.
   - Required: four consecutive out_valid cycles, in order.
3. Backpressure: out_ready=0; accept A then B -> in_ready=0 the cycle after B, C held at the input. Raise out_ready -> A, B, C emerge in order with no loss or duplicate. A stays stable while stalled.
4. Unrecognised opcodes, CNT_W=2: accept 0x00000000 five times -> each output has imm 0, fmt 0, known 0; err_cnt goes 1, 2, 3, 3, 3.
5. XLEN=32: 0x800000B7 -> imm 0x80000000; 0xFF813083 -> imm 0xFFFFFFF8.
6. Reset mid-operation: reach TWO state with err_cnt=2, then pulse rst_n=0 for one cycle -> out_valid=0, all outputs 0, err_cnt=0. in_ready=1 the cycle after release; a new word passes normally.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: RV32I/RV64I immediate generator (I/S/B/U/J) with one-cycle
// registered latency behind a valid/ready output register plus skid register.
// Revision: 1.0
`default_nettype none

module imm_gen_pipe #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm_out,
  output logic [2:0]       imm_fmt,
  output logic             imm_known,
  output logic [TAG_W-1:0] out_tag,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [2:0] c_fmt_none = 3'd0;
  localparam logic [2:0] c_fmt_i    = 3'd1;
  localparam logic [2:0] c_fmt_s    = 3'd2;
  localparam logic [2:0] c_fmt_b    = 3'd3;
  localparam logic [2:0] c_fmt_u    = 3'd4;
  localparam logic [2:0] c_fmt_j    = 3'd5;

  logic [31:0]      w_imm32;
  logic [2:0]       w_fmt;
  logic             w_known;
  logic [XLEN-1:0]  w_imm;
  logic             w_accept;
  logic             w_xfer;

  logic             out_valid_q;
  logic [XLEN-1:0]  out_imm_q;
  logic [2:0]       out_fmt_q;
  logic             out_known_q;
  logic [TAG_W-1:0] out_tag_q;
  logic             skid_valid_q;
  logic [XLEN-1:0]  skid_imm_q;
  logic [2:0]       skid_fmt_q;
  logic             skid_known_q;
  logic [TAG_W-1:0] skid_tag_q;
  logic [CNT_W-1:0] err_q;
  logic [CNT_W-1:0] err_d;

  always_comb begin
    w_imm32 = 32'h0;
    w_fmt   = c_fmt_none;
    w_known = 1'b0;
    case (instr[6:0])
      7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111: begin
        w_imm32 = {{20{instr[31]}}, instr[31:20]};
        w_fmt   = c_fmt_i;
        w_known = 1'b1;
      end
      7'b0100011: begin
        w_imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        w_fmt   = c_fmt_s;
        w_known = 1'b1;
      end
      7'b1100011: begin
        w_imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        w_fmt   = c_fmt_b;
        w_known = 1'b1;
      end
      7'b0110111, 7'b0010111: begin
        w_imm32 = {instr[31:12], 12'h000};
        w_fmt   = c_fmt_u;
        w_known = 1'b1;
      end
      7'b1101111: begin
        w_imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        w_fmt   = c_fmt_j;
        w_known = 1'b1;
      end
      default: begin
        w_imm32 = 32'h0;
        w_fmt   = c_fmt_none;
        w_known = 1'b0;
      end
    endcase
  end

  // Extend from the decoded value so unrecognised opcodes stay exactly zero.
  generate
    if (XLEN > 32) begin : g_ext_wide
      assign w_imm = {{(XLEN-32){w_imm32[31]}}, w_imm32};
    end else begin : g_ext_none
      assign w_imm = w_imm32;
    end
  endgenerate

  // in_ready depends only on reset and the registered skid flag, never on out_ready.
  assign in_ready = rst_n & ~skid_valid_q;
  assign w_accept = in_valid & in_ready;
  assign w_xfer   = out_valid_q & out_ready;

  always_comb begin
    err_d = err_q;
    if (w_accept && !w_known && (err_q != {CNT_W{1'b1}})) begin
      err_d = err_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_imm_q    <= '0;
      out_fmt_q    <= c_fmt_none;
      out_known_q  <= 1'b0;
      out_tag_q    <= '0;
      skid_valid_q <= 1'b0;
      skid_imm_q   <= '0;
      skid_fmt_q   <= c_fmt_none;
      skid_known_q <= 1'b0;
      skid_tag_q   <= '0;
      err_q        <= '0;
    end else begin
      if (w_xfer || !out_valid_q) begin
        if (skid_valid_q) begin
          out_valid_q  <= 1'b1;
          out_imm_q    <= skid_imm_q;
          out_fmt_q    <= skid_fmt_q;
          out_known_q  <= skid_known_q;
          out_tag_q    <= skid_tag_q;
          skid_valid_q <= 1'b0;
        end else if (w_accept) begin
          out_valid_q  <= 1'b1;
          out_imm_q    <= w_imm;
          out_fmt_q    <= w_fmt;
          out_known_q  <= w_known;
          out_tag_q    <= in_tag;
        end else begin
          out_valid_q  <= 1'b0;
        end
      end else if (w_accept) begin
        skid_valid_q <= 1'b1;
        skid_imm_q   <= w_imm;
        skid_fmt_q   <= w_fmt;
        skid_known_q <= w_known;
        skid_tag_q   <= in_tag;
      end
      err_q <= err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign imm_out   = out_imm_q;
  assign imm_fmt   = out_fmt_q;
  assign imm_known = out_known_q;
  assign out_tag   = out_tag_q;
  assign err_cnt   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: table vectors plus handshake corner sequences, scoreboarded
// against an XLEN=64/CNT_W=2 instance and an XLEN=32 instance sharing inputs.
`default_nettype none

module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] instr;
  logic [7:0]  in_tag;
  logic        out_ready;

  logic        in_ready64, out_valid64, known64;
  logic [63:0] imm64;
  logic [2:0]  fmt64;
  logic [7:0]  tag64;
  logic [1:0]  err64;

  logic        in_ready32, out_valid32, known32;
  logic [31:0] imm32;
  logic [2:0]  fmt32;
  logic [7:0]  tag32;
  logic [7:0]  err32;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(64), .TAG_W(8), .CNT_W(2)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready64),
    .instr(instr), .in_tag(in_tag), .out_valid(out_valid64), .out_ready(out_ready),
    .imm_out(imm64), .imm_fmt(fmt64), .imm_known(known64), .out_tag(tag64),
    .err_cnt(err64)
  );

  imm_gen_pipe #(.XLEN(32), .TAG_W(8), .CNT_W(8)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready32),
    .instr(instr), .in_tag(in_tag), .out_valid(out_valid32), .out_ready(out_ready),
    .imm_out(imm32), .imm_fmt(fmt32), .imm_known(known32), .out_tag(tag32),
    .err_cnt(err32)
  );

  typedef struct {
    logic [31:0] instr;
    logic [7:0]  tag;
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        known;
  } vec_t;

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        known;
    logic [7:0]  tag;
  } exp_t;

  exp_t q64[$];
  exp_t q32[$];
  exp_t cur;
  int   checks;
  int   failures;
  logic [7:0] valid_hist;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic monitor();
    exp_t e;
    valid_hist = {valid_hist[6:0], out_valid64 === 1'b1};
    if (out_valid64 === 1'b1 && out_ready) begin
      if (q64.size() == 0) begin
        chk("unexpected_out64", 64'd1, 64'd0);
      end else begin
        e = q64.pop_front();
        chk("imm64", imm64, e.imm);
        chk("fmt64", {61'h0, fmt64}, {61'h0, e.fmt});
        chk("known64", {63'h0, known64}, {63'h0, e.known});
        chk("tag64", {56'h0, tag64}, {56'h0, e.tag});
      end
    end
    if (out_valid32 === 1'b1 && out_ready) begin
      if (q32.size() == 0) begin
        chk("unexpected_out32", 64'd1, 64'd0);
      end else begin
        e = q32.pop_front();
        chk("imm32", {32'h0, imm32}, {32'h0, e.imm[31:0]});
        chk("fmt32", {61'h0, fmt32}, {61'h0, e.fmt});
        chk("tag32", {56'h0, tag32}, {56'h0, e.tag});
      end
    end
  endtask

  // One clock: observe at the falling edge, then return 1 time unit after the rising edge.
  task automatic tick(output bit acc);
    @(negedge clk);
    monitor();
    acc = 1'b0;
    if (in_valid && in_ready64 === 1'b1) begin
      q64.push_back(cur);
      q32.push_back(cur);
      acc = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] ins, input logic [7:0] tg,
                      input logic [63:0] im, input logic [2:0] f, input logic k);
    bit acc;
    acc      = 1'b0;
    in_valid = 1'b1;
    instr    = ins;
    in_tag   = tg;
    cur      = '{imm: im, fmt: f, known: k, tag: tg};
    for (int i = 0; i < 20; i++) begin
      tick(acc);
      if (acc) break;
    end
    if (!acc) chk("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    bit acc;
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (q64.size() == 0 && q32.size() == 0) break;
      tick(acc);
    end
    chk("drain_left", 64'(q64.size() + q32.size()), 64'd0);
  endtask

  task automatic do_reset();
    bit acc;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    tick(acc);
    tick(acc);
    q64.delete();
    q32.delete();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[12];
    bit   acc;
    int   exp_err[5];
    exp_t a_exp;

    checks     = 0;
    failures   = 0;
    valid_hist = 8'h0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    instr      = 32'h0;
    in_tag     = 8'h0;
    out_ready  = 1'b1;
    cur        = '{imm: 64'h0, fmt: 3'd0, known: 1'b0, tag: 8'h0};

    vecs[0]  = '{32'hFF813083, 8'h20, 64'hFFFFFFFFFFFFFFF8, 3'd1, 1'b1};
    vecs[1]  = '{32'h7FF00093, 8'h21, 64'h00000000000007FF, 3'd1, 1'b1};
    vecs[2]  = '{32'hFFF08067, 8'h22, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b1};
    vecs[3]  = '{32'h8001009B, 8'h23, 64'hFFFFFFFFFFFFF800, 3'd1, 1'b1};
    vecs[4]  = '{32'h7E000FA3, 8'h24, 64'h00000000000007FF, 3'd2, 1'b1};
    vecs[5]  = '{32'h80000063, 8'h25, 64'hFFFFFFFFFFFFF000, 3'd3, 1'b1};
    vecs[6]  = '{32'h12345297, 8'h26, 64'h0000000012345000, 3'd4, 1'b1};
    vecs[7]  = '{32'h800000B7, 8'h27, 64'hFFFFFFFF80000000, 3'd4, 1'b1};
    vecs[8]  = '{32'h8000006F, 8'h28, 64'hFFFFFFFFFFF00000, 3'd5, 1'b1};
    vecs[9]  = '{32'hFFFFFFFF, 8'h29, 64'h0000000000000000, 3'd0, 1'b0};
    vecs[10] = '{32'h00000033, 8'h2A, 64'h0000000000000000, 3'd0, 1'b0};
    vecs[11] = '{32'h001000EF, 8'h2B, 64'h0000000000000800, 3'd5, 1'b1};
    exp_err  = '{1, 2, 3, 3, 3};

    // Reset state
    tick(acc);
    tick(acc);
    chk("rst_out_valid", {63'h0, out_valid64}, 64'd0);
    chk("rst_imm", imm64, 64'd0);
    chk("rst_fmt", {61'h0, fmt64}, 64'd0);
    chk("rst_known", {63'h0, known64}, 64'd0);
    chk("rst_tag", {56'h0, tag64}, 64'd0);
    chk("rst_err", {62'h0, err64}, 64'd0);
    chk("rst_in_ready", {63'h0, in_ready64}, 64'd0);
    chk("rst_out_valid32", {63'h0, out_valid32}, 64'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", {63'h0, in_ready64}, 64'd1);

    // Single word, one-cycle latency
    send(32'hFF813083, 8'h11, 64'hFFFFFFFFFFFFFFF8, 3'd1, 1'b1);
    in_valid = 1'b0;
    chk("lat_out_valid", {63'h0, out_valid64}, 64'd1);
    chk("lat_imm", imm64, 64'hFFFFFFFFFFFFFFF8);
    chk("lat_tag", {56'h0, tag64}, 64'h11);
    drain();

    // Back-to-back throughput
    send(32'h00513823, 8'h01, 64'h0000000000000010, 3'd2, 1'b1);
    send(32'hFE000EE3, 8'h02, 64'hFFFFFFFFFFFFFFFC, 3'd3, 1'b1);
    send(32'h800000B7, 8'h03, 64'hFFFFFFFF80000000, 3'd4, 1'b1);
    send(32'h001000EF, 8'h04, 64'h0000000000000800, 3'd5, 1'b1);
    in_valid = 1'b0;
    tick(acc);
    tick(acc);
    chk("b2b_valid_run", {58'h0, valid_hist[5:0]}, 64'b011110);
    drain();

    // Table vectors across all formats and sign boundaries
    for (int i = 0; i < 12; i++) begin
      send(vecs[i].instr, vecs[i].tag, vecs[i].imm, vecs[i].fmt, vecs[i].known);
    end
    drain();

    // Backpressure: fill both entries, hold C at the input
    out_ready = 1'b0;
    a_exp = '{imm: 64'h0000000000000004, fmt: 3'd1, known: 1'b1, tag: 8'hA0};
    send(32'h00400093, 8'hA0, 64'h0000000000000004, 3'd1, 1'b1);
    send(32'hFE112E23, 8'hB0, 64'hFFFFFFFFFFFFFFFC, 3'd2, 1'b1);
    in_valid = 1'b1;
    instr    = 32'h00001137;
    in_tag   = 8'hC0;
    cur      = '{imm: 64'h0000000000001000, fmt: 3'd4, known: 1'b1, tag: 8'hC0};
    for (int i = 0; i < 3; i++) begin
      tick(acc);
      chk("bp_c_held", {63'h0, acc}, 64'd0);
      chk("bp_in_ready", {63'h0, in_ready64}, 64'd0);
      chk("bp_a_stable_imm", imm64, a_exp.imm);
      chk("bp_a_stable_tag", {56'h0, tag64}, {56'h0, a_exp.tag});
    end
    out_ready = 1'b1;
    send(32'h00001137, 8'hC0, 64'h0000000000001000, 3'd4, 1'b1);
    drain();

    // Saturating error counter (CNT_W=2)
    do_reset();
    for (int k = 0; k < 5; k++) begin
      send(32'h00000000, 8'(8'h50 + k), 64'h0, 3'd0, 1'b0);
      chk("err_cnt_sat", {62'h0, err64}, 64'(exp_err[k]));
    end
    drain();

    // XLEN=32 sign extension
    send(32'h800000B7, 8'h61, 64'hFFFFFFFF80000000, 3'd4, 1'b1);
    chk("x32_lui", {32'h0, imm32}, 64'h0000000080000000);
    send(32'hFF813083, 8'h62, 64'hFFFFFFFFFFFFFFF8, 3'd1, 1'b1);
    chk("x32_ld", {32'h0, imm32}, 64'h00000000FFFFFFF8);
    drain();

    // Reset while both entries are full, with a word offered during reset
    do_reset();
    out_ready = 1'b0;
    send(32'h0000007F, 8'h71, 64'h0, 3'd0, 1'b0);
    send(32'h0000007F, 8'h72, 64'h0, 3'd0, 1'b0);
    chk("two_err", {62'h0, err64}, 64'd2);
    chk("two_in_ready", {63'h0, in_ready64}, 64'd0);
    rst_n    = 1'b0;
    in_valid = 1'b1;
    instr    = 32'hFFFFFFFF;
    in_tag   = 8'h73;
    cur      = '{imm: 64'h0, fmt: 3'd0, known: 1'b0, tag: 8'h73};
    tick(acc);
    chk("mid_rst_no_accept", {63'h0, acc}, 64'd0);
    chk("mid_rst_out_valid", {63'h0, out_valid64}, 64'd0);
    chk("mid_rst_imm", imm64, 64'd0);
    chk("mid_rst_fmt", {61'h0, fmt64}, 64'd0);
    chk("mid_rst_known", {63'h0, known64}, 64'd0);
    chk("mid_rst_tag", {56'h0, tag64}, 64'd0);
    chk("mid_rst_err", {62'h0, err64}, 64'd0);
    chk("mid_rst_in_ready", {63'h0, in_ready64}, 64'd0);
    q64.delete();
    q32.delete();
    rst_n    = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("mid_rel_in_ready", {63'h0, in_ready64}, 64'd1);
    out_ready = 1'b1;
    send(32'h00C00513, 8'h74, 64'h000000000000000C, 3'd1, 1'b1);
    in_valid = 1'b0;
    chk("post_rst_valid", {63'h0, out_valid64}, 64'd1);
    chk("post_rst_err", {62'h0, err64}, 64'd0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
